// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a RAM address range and streams the words out as ready/valid beats.
// Defining RAM_STREAM_READER_LAST_EN adds a last_o marker on the final beat of each transfer.
module ram_stream_reader #(
    parameter int width_p = 8,
    parameter int depth_p = 512,
    localparam int aw = $clog2(depth_p)
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               start_i,
    input  logic [aw-1:0]      base_addr_i,
    input  logic [aw:0]        len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               rd_valid_o,
    output logic [aw-1:0]      rd_addr_o,
    input  logic [width_p-1:0] rd_data_i,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
`ifdef RAM_STREAM_READER_LAST_EN
    ,
    output logic               last_o
`endif
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    localparam logic [aw-1:0] LastAddr = aw'(depth_p - 1);

    state_e             state_q, state_d;
    logic [aw-1:0]      addr_q, addr_d;
    logic [aw:0]        len_q, len_d;
    logic [aw:0]        issued_q, issued_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         count_q, count_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [width_p-1:0] buf_q [2];
    logic [width_p-1:0] buf_d [2];
    logic               issue;
    logic               push;
    logic               pop;
    logic [2:0]         credit_used;

    assign pop         = valid_o & ready_i;
    assign push        = inflight_q;
    assign valid_o     = (count_q != 2'd0);
    assign data_o      = buf_q[rd_ptr_q];
    assign credit_used = {1'b0, count_q} + {2'b00, inflight_q};
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign rd_valid_o  = issue;
    assign rd_addr_o   = addr_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d   = base_addr_i;
                        len_d    = len_i;
                        issued_d = '0;
                        state_d  = READ;
                    end
                end
            end
            READ: begin
                // A popped slot is reusable in the same cycle, so the pop counts as a credit.
                issue = (credit_used < (3'd2 + {2'b00, pop}));
                if (issue) begin
                    addr_d   = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if ((issued_q + 1'b1) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (count_q == 2'd1) && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = issue;
        if (push) begin
            buf_d[wr_ptr_q] = rd_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

`ifdef RAM_STREAM_READER_LAST_EN
    logic [aw:0] beats_q, beats_d;

    always_comb begin
        beats_d = beats_q;
        if ((state_q == IDLE) && start_i) begin
            beats_d = '0;
        end else if (pop) begin
            beats_d = beats_q + 1'b1;
        end
    end

    assign last_o = valid_o && (beats_q == (len_q - 1'b1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model, transfer-level reference model and directed tests.
module tb_ram_stream_reader;
    localparam int W  = 8;
    localparam int D  = 512;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset_ni = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW:0]   len_i = '0;
    logic          busy_o, done_o, rd_valid_o, valid_o;
    logic [AW-1:0] rd_addr_o;
    logic [W-1:0]  rd_data_i = '0;
    logic [W-1:0]  data_o;
    logic          ready_i = 1'b0;
`ifdef RAM_STREAM_READER_LAST_EN
    logic          last_o;
`endif

    logic [W-1:0]  ram_mem [D];
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] addr_log [$];
    logic [W-1:0]  beat_log [$];
    logic          last_log [$];

    ram_stream_reader #(.width_p(W), .depth_p(D)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .rd_valid_o(rd_valid_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i)
`ifdef RAM_STREAM_READER_LAST_EN
        , .last_o(last_o)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after the request.
    always @(posedge clk) begin
        if (rd_valid_o) rd_data_i <= ram_mem[rd_addr_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: counts of issued, arrived and popped words decide every output.
    initial begin
        bit m_active, m_done_now, done_next, e_valid, e_pop, e_rdv, prev_stall;
        int m_base, m_len, m_issued, m_arrived, m_popped;
        logic [W-1:0] prev_data;
        m_active = 0; m_done_now = 0; prev_stall = 0; prev_data = '0;
        m_base = 0; m_len = 0; m_issued = 0; m_arrived = 0; m_popped = 0;
        forever begin
            @(negedge clk);
            if (!reset_ni) begin
                m_active = 0; m_done_now = 0; prev_stall = 0;
                m_issued = 0; m_arrived = 0; m_popped = 0;
            end else begin
                e_valid = m_active && (m_arrived > m_popped);
                e_pop   = e_valid && ready_i;
                e_rdv   = m_active && (m_issued < m_len) &&
                          ((m_issued - m_popped - (e_pop ? 1 : 0)) < 2);
                chk("busy", 32'(busy_o), 32'(m_active || m_done_now));
                chk("done", 32'(done_o), 32'(m_done_now));
                chk("rd_valid", 32'(rd_valid_o), 32'(e_rdv));
                chk("valid", 32'(valid_o), 32'(e_valid));
                if (e_rdv) chk("rd_addr", 32'(rd_addr_o), 32'((m_base + m_issued) % D));
                if (e_valid) chk("data", 32'(data_o), 32'(ram_mem[9'((m_base + m_popped) % D)]));
`ifdef RAM_STREAM_READER_LAST_EN
                chk("last", 32'(last_o), 32'(e_valid && (m_popped == m_len - 1)));
`endif
                if (prev_stall) begin
                    chk("stall_valid", 32'(valid_o), 32'd1);
                    chk("stall_data", 32'(data_o), 32'(prev_data));
                end
                if (rd_valid_o) addr_log.push_back(rd_addr_o);
                if (valid_o && ready_i) begin
                    beat_log.push_back(data_o);
`ifdef RAM_STREAM_READER_LAST_EN
                    last_log.push_back(last_o);
`else
                    last_log.push_back(1'b0);
`endif
                end
                prev_stall = valid_o && !ready_i;
                prev_data  = data_o;
                done_next = 0;
                if (m_active) begin
                    m_arrived = m_issued;
                    m_issued += e_rdv ? 1 : 0;
                    m_popped += e_pop ? 1 : 0;
                    if (m_popped == m_len) begin
                        m_active  = 0;
                        done_next = 1;
                    end
                end else if (!m_done_now && start_i) begin
                    if (len_i == '0) begin
                        done_next = 1;
                    end else begin
                        m_active = 1; m_base = int'(base_addr_i); m_len = int'(len_i);
                        m_issued = 0; m_arrived = 0; m_popped = 0;
                    end
                end
                m_done_now = done_next;
            end
        end
    end

    task automatic start_xfer(input int base, input int len);
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = 9'(base); len_i = 10'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, 32'(busy_o), 32'd0);
        chk({name, "_done"}, 32'(done_o), 32'd0);
        chk({name, "_rdv"}, 32'(rd_valid_o), 32'd0);
        chk({name, "_addr"}, 32'(rd_addr_o), 32'd0);
        chk({name, "_valid"}, 32'(valid_o), 32'd0);
        chk({name, "_data"}, 32'(data_o), 32'd0);
`ifdef RAM_STREAM_READER_LAST_EN
        chk({name, "_last"}, 32'(last_o), 32'd0);
`endif
    endtask

    initial begin
        int amark, bmark;
        bit seen;
        int c;
        logic [3:0] pat;
        for (int i = 0; i < D; i++) ram_mem[i] = 8'(i * 7 + 3);
        ram_mem[16] = 8'hA0; ram_mem[17] = 8'hA1; ram_mem[18] = 8'hA2; ram_mem[19] = 8'hA3;

        #1 reset_ni = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 reset_ni = 1'b1;

        // Basic transfer with literal timing
        ready_i = 1'b1;
        bmark = beat_log.size();
        start_xfer(16, 4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            case (k)
                1: begin
                    chk("t1_rdv_k1", 32'(rd_valid_o), 32'd1);
                    chk("t1_addr_k1", 32'(rd_addr_o), 32'h010);
                    chk("t1_valid_k1", 32'(valid_o), 32'd0);
                end
                2: chk("t1_valid_k2", 32'(valid_o), 32'd0);
                3: begin chk("t1_v3", 32'(valid_o), 32'd1); chk("t1_d3", 32'(data_o), 32'hA0); end
                4: begin chk("t1_v4", 32'(valid_o), 32'd1); chk("t1_d4", 32'(data_o), 32'hA1); end
                5: begin chk("t1_v5", 32'(valid_o), 32'd1); chk("t1_d5", 32'(data_o), 32'hA2); end
                6: begin chk("t1_v6", 32'(valid_o), 32'd1); chk("t1_d6", 32'(data_o), 32'hA3); end
                default: chk("t1_done_k7", 32'(done_o), 32'd1);
            endcase
        end
        chk("t1_beats", 32'(beat_log.size() - bmark), 32'd4);

        // Address wrap at the top of the RAM
        amark = addr_log.size(); bmark = beat_log.size();
        start_xfer(9'h1FE, 4);
        wait_done("t2_done", 20);
        chk("t2_naddr", 32'(addr_log.size() - amark), 32'd4);
        if (addr_log.size() - amark == 4) begin
            chk("t2_a0", 32'(addr_log[amark]), 32'h1FE);
            chk("t2_a1", 32'(addr_log[amark + 1]), 32'h1FF);
            chk("t2_a2", 32'(addr_log[amark + 2]), 32'h000);
            chk("t2_a3", 32'(addr_log[amark + 3]), 32'h001);
        end
        chk("t2_nbeat", 32'(beat_log.size() - bmark), 32'd4);
        if (beat_log.size() - bmark == 4) begin
            chk("t2_d0", 32'(beat_log[bmark]), 32'hF5);
            chk("t2_d1", 32'(beat_log[bmark + 1]), 32'hFC);
            chk("t2_d2", 32'(beat_log[bmark + 2]), 32'h03);
            chk("t2_d3", 32'(beat_log[bmark + 3]), 32'h0A);
        end

        // Backpressure: ready toggles 1,0,0,1
        bmark = beat_log.size();
        pat = 4'b1001;
        start_xfer(32, 8);
        seen = 0; c = 0;
        while (!seen && c < 200) begin
            ready_i = pat[c % 4];
            @(negedge clk);
            if (done_o) seen = 1;
            @(posedge clk); #1;
            c++;
        end
        chk("t3_done", 32'(seen), 32'd1);
        ready_i = 1'b1;
        chk("t3_nbeat", 32'(beat_log.size() - bmark), 32'd8);
        if (beat_log.size() - bmark == 8) begin
            chk("t3_d0", 32'(beat_log[bmark]), 32'hE3);
            chk("t3_d3", 32'(beat_log[bmark + 3]), 32'hF8);
            chk("t3_d5", 32'(beat_log[bmark + 5]), 32'h06);
            chk("t3_d7", 32'(beat_log[bmark + 7]), 32'h14);
        end

        // Zero-length transfer
        amark = addr_log.size(); bmark = beat_log.size();
        start_xfer(9'h055, 0);
        @(negedge clk);
        chk("t4_done", 32'(done_o), 32'd1);
        chk("t4_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("t4_done_low", 32'(done_o), 32'd0);
        chk("t4_idle", 32'(busy_o), 32'd0);
        chk("t4_noreads", 32'(addr_log.size() - amark), 32'd0);
        chk("t4_nobeats", 32'(beat_log.size() - bmark), 32'd0);

        // start re-pulsed mid-transfer is ignored
        amark = addr_log.size(); bmark = beat_log.size();
        start_xfer(9'h040, 4);
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = 9'h100; len_i = 10'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done("t5_done", 20);
        chk("t5_naddr", 32'(addr_log.size() - amark), 32'd4);
        if (addr_log.size() - amark == 4) begin
            chk("t5_a0", 32'(addr_log[amark]), 32'h040);
            chk("t5_a3", 32'(addr_log[amark + 3]), 32'h043);
        end
        chk("t5_nbeat", 32'(beat_log.size() - bmark), 32'd4);

        // Reset on the third beat, then a fresh 2-word transfer
        start_xfer(9'h080, 6);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_beat3_valid", 32'(valid_o), 32'd1);
        chk("t6_beat3_data", 32'(data_o), 32'h91);
        reset_ni = 1'b0;
        #1 chk_reset_outputs("t6_rst");
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        bmark = beat_log.size();
        start_xfer(9'h0A0, 2);
        wait_done("t6_done", 20);
        chk("t6_nbeat", 32'(beat_log.size() - bmark), 32'd2);
        if (beat_log.size() - bmark == 2) begin
            chk("t6_d0", 32'(beat_log[bmark]), 32'h63);
            chk("t6_d1", 32'(beat_log[bmark + 1]), 32'h6A);
`ifdef RAM_STREAM_READER_LAST_EN
            chk("t6_last0", 32'(last_log[bmark]), 32'd0);
            chk("t6_last1", 32'(last_log[bmark + 1]), 32'd1);
`endif
        end
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side master for `ram_1r1w_sync` memories in the conv2d datapath. It walks a contiguous address range, issues synchronous read requests, absorbs the one-cycle RAM read latency, and presents the words as a ready/valid stream to downstream kernels. A 2-entry output buffer with credit-based issue keeps full throughput of one word per cycle and never drops data under backpressure.

## Interface
- `width_p`, 8: word width; matches the attached RAM.
- `depth_p`, 512: RAM depth. Address width is `aw = $clog2(depth_p)`.
- `clk_i` input, 1: clock; all logic on the rising edge.
- `reset_ni` input, 1: asynchronous active-low reset.
- `start_i` input, 1: begin a transfer; sampled only in IDLE.
- `base_addr_i` input, aw: first address; latched with `start_i`.
- `len_i` input, aw+1: word count, 0..depth_p; latched with `start_i`.
- `busy_o` output, 1: high in every state except IDLE.
- `done_o` output, 1: one-cycle pulse when a transfer completes.
- `rd_valid_o` output, 1: RAM read enable.
- `rd_addr_o` output, aw: RAM read address.
- `rd_data_i` input, width_p: RAM read data, valid the cycle after `rd_valid_o`.
- `valid_o` output, 1: stream word available.
- `data_o` output, width_p: stream word.
- `ready_i` input, 1: downstream accepts; a beat transfers when `valid_o & ready_i`.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: `start_i=1` with `len_i>0` latches the base address and length, clears the issued count, and moves to READ. `start_i=1` with `len_i=0` moves directly to DONE. `start_i` has no effect in all other states.
- READ: `rd_valid_o=1` exactly when `count + inflight - pop < 2`, where:
  - `count` is the buffer occupancy (0..2),
  - `inflight` is 1 if a read was issued in the previous cycle,
  - `pop` is `valid_o & ready_i`.
- Each issued read post-increments the address. The address wraps from depth_p-1 to 0 with modulo-2^aw arithmetic when depth_p is a power of two; otherwise it explicitly resets to 0 after depth_p-1.
- When the issued count reaches the length, the block moves to DRAIN.
- DRAIN: `rd_valid_o=0`. The block moves to DONE on the cycle the final beat is popped. If the final beat pops in the same cycle as the last issue, it skips directly to DONE.
- DONE: `done_o=1` for exactly one cycle, then the block returns to IDLE.
- Buffer:
  - 2-entry FIFO. The word returned on `rd_data_i` is pushed in the cycle after the issue.
  - Push and pop in the same cycle is legal at any occupancy 1..2.
  - The credit rule guarantees no push occurs when the buffer is full; pushing into a full buffer is a design error.
- `data_o` always equals the head entry. `data_o` and `valid_o` stay stable while `valid_o & ~ready_i`.
- `rd_addr_o` holds its last value when `rd_valid_o=0`.

## Timing
- Reset values: state IDLE, `busy_o=0`, `done_o=0`, `rd_valid_o=0`, `rd_addr_o=0`, `valid_o=0`, `data_o=0`, buffer empty, inflight 0.
- `start_i` sampled at edge E0 → `rd_valid_o=1` with `rd_addr_o=base` in the cycle after E0 → `valid_o=1` after E2. Start-to-first-beat latency is 2 cycles.
- With `ready_i` held high: one beat per cycle. `done_o` asserts the cycle after the last beat pops, so a transfer of N words takes N+2 cycles from start to `done_o`.
- `ready_i` low for K cycles: issue stops once `count + inflight = 2`. Issue resumes in the same cycle `ready_i` returns high.
- Reset asserted mid-transfer:
  - Takes effect immediately and asynchronously on all state.
  - A RAM read in flight is discarded.
  - No `done_o` is produced.

## Configuration
- `RAM_STREAM_READER_LAST_EN`:
  - Defined: adds output `last_o` (1 bit). `last_o` is high together with `valid_o` on the final beat of a transfer only; it is held with the data under backpressure and resets to 0.
  - Undefined: the port is absent and downstream logic counts beats itself.

## Test plan
- Reset, then base=0x010, len=4, `ready_i=1`, RAM[0x10..0x13]=A0..A3 → `valid_o` first high 2 cycles after start; data A0,A1,A2,A3 on consecutive cycles; `done_o` pulses 6 cycles after start.
- base=0x1FE, len=4, depth_p=512 → reads addresses 0x1FE, 0x1FF, 0x000, 0x001 in order; data matches.
- len=8 with `ready_i` toggling 1,0,0,1 repeating → all 8 words delivered in order with none duplicated or dropped; `rd_valid_o` never issues when count+inflight=2; data stays stable during stalls.
- len=0 → `done_o` the cycle after start; `rd_valid_o` and `valid_o` never assert.
- `start_i` re-pulsed mid-transfer with different base and len → ignored; the original transfer completes unchanged.
- `reset_ni` dropped on the 3rd beat of a len=6 transfer → all outputs go to reset values immediately; a new len=2 start after release delivers exactly 2 correct words. With `RAM_STREAM_READER_LAST_EN` defined, `last_o` is high only on the 2nd beat.
